decode_queue: RTL
=================

# decode_queue

Parametrised, multi-lane decode stage with an output buffer. Accepts up to `WIDTH` fetched instructions per cycle, decodes each lane combinationally into the team's control-word format, and holds the results in a circular queue of `DEPTH` entries. Downstream rename/dispatch drains the queue in order, up to `WIDTH` entries per cycle. Sits between fetch and rename; its valid/ready handshake and flush take over from the single-lane, non-stalling decode register.

## Interface
- `WIDTH`, 2: lanes per cycle, in and out (1..4).
- `DEPTH`, 8: queue entries; power of two, `DEPTH >= 2*WIDTH`.
- `PC_W`, 32: PC tag width carried with each entry.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: discard all queued entries.
- `in_valid` in WIDTH: per-lane instruction valid; lane 0 = oldest.
- `in_instr` in 32*WIDTH: raw instructions, lane i at [32i+31:32i].
- `in_pc` in PC_W*WIDTH: PC per lane.
- `in_ready` out 1: queue accepts a full `WIDTH` group this cycle.
- `out_valid` out WIDTH: lane i holds the i-th oldest entry.
- `out_op` out OP_W*WIDTH: packed `dec_op_t` per lane.
- `out_accept` in $clog2(WIDTH+1): number of entries consumed this cycle, taken from lane 0 upward.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- Per-lane decode on `opcode = instr[6:0]`, `func3 = instr[14:12]`:
  - 0110011 R: rd/rs1/rs2 from the fields, imm 0, RegWrite 1, ALUSrc 0. ALU is ADD(0010) when func3=000; XOR(0011) otherwise.
  - 0010011 I: rs2 0, ALUSrc 1, RegWrite 1.
    - func3=000: ADD, imm = sext(instr[31:20]).
    - func3=110: OR(0001), imm = sext(instr[31:20]).
    - func3=101: SRA(1011), imm = zext(instr[24:20]).
  - 0000011 LOAD: imm = sext(I-imm), LoadStore 1, ALUSrc 1, RegWrite 1, ALU ADD. BMS = (func3==000) of the **same** instruction.
  - 0100011 STORE: rd 0, imm = sext({instr[31:25],instr[11:7]}), LoadStore 1, ALUSrc 1, RegWrite 0, ALU ADD. BMS as for LOAD.
  - 0110111 LUI: rd only, imm = {instr[31:12],12'b0}, ALUSrc 1, RegWrite 1, ALU PASS(1111).
  - Anything else: all-zero op, ALU NOP(0000). Illegal handling per Configuration.
- Enqueue: only the contiguous prefix of set `in_valid` bits starting at lane 0 is written. Bits after the first zero are ignored. Enqueue happens only when `in_ready`=1.
- `in_ready` = (DEPTH − count) ≥ WIDTH. It uses the current count only and has no combinational path from `out_accept`.
- Dequeue: `out_valid[i]` = (count > i). `out_accept` greater than the valid count is clamped to the valid count.
- Enqueue and dequeue in the same cycle: count_next = count + n_in − n_out. Pointers wrap modulo DEPTH.
- `flush`: count, head and tail go to 0 at the next edge. It overrides any same-cycle enqueue or dequeue.
- `reset` behaves like `flush` and also clears stored entries. Reset values: `in_ready`=1, `out_valid`=0, `out_op`=0, `count`=0.

## Timing
- Latency is 1 cycle: an instruction enqueued at edge N appears on `out_valid`/`out_op` after edge N. There is no same-cycle bypass when empty.
- `out_op` is driven from storage; a lane stays stable while it is valid and not accepted.
- Full queue: `in_ready`=0 and input is ignored.
- Empty queue: `out_valid`=0 and `out_accept` is ignored.
- Full throughput of WIDTH per cycle is sustained when the consumer accepts WIDTH every cycle.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - `dec_op_t.illegal` is set for an unknown opcode, R-type func3 ∉ {000,100}, I-type func3 ∉ {000,110,101}, LOAD func3 ∉ {000,010}, or STORE func3 ∉ {000,010}.
  - Illegal entries are still enqueued with an all-zero control word and the PC kept.
- Not defined: the `illegal` bit is tied to 0. Unsupported encodings decode by the rules above with no flag, so unknown opcodes become NOPs.

## Structure
- `decode_pkg`:
  - `dec_op_t`: pc, opcode, rd, rs1, rs2, imm, func3, LoadStore, ALUSrc, RegWrite, ALUControl, BMS, illegal.
  - `OP_W`.
  - Opcode constants and ALU codes (ALU_NOP, ALU_OR, ALU_ADD, ALU_XOR, ALU_SRA, ALU_PASS).
- Sub-module `decode_lane`: purely combinational, instr+pc → `dec_op_t`, instantiated WIDTH times. `decode_queue` holds the storage, pointers and handshake.

## Test plan
- After reset, WIDTH=2: lane0 `0x002081B3`, lane1 `0x00500093`, both valid, `out_accept`=0.
  - Next cycle `out_valid`=11, count=2.
  - Lane0: ADD, rd3 rs1 1 rs2 2.
  - Lane1: ADD, imm 5, ALUSrc 1.
- `0x4033D313`: SRA(1011), rd6 rs1 7, imm 3. `0x123452B7`: imm `0x12345000`, ALU 1111.
- `0xFFC10203`: imm `0xFFFFFFFC`, BMS 1, LoadStore 1. `0x0020A423`: imm 8, rd0, RegWrite 0, BMS 0.
- Feed 2/cycle with `out_accept`=0 (DEPTH=8): `in_ready` drops when count=7 or 8. Then `out_accept`=2 with new input each cycle: count holds, order is preserved across pointer wrap.
- `in_valid`=10: nothing enqueued. `flush` together with valid input and `out_accept`=2: count=0 next cycle.
- With `DECODE_ILLEGAL_TRAP_EN`: `0x0000007F` gives illegal=1 and an all-zero control word. Without it, illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Module : decode_pkg
// Brief  : Shared control-word type, opcode and ALU constants for decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int PC_W_MAX = 32;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [2:0]          func3;
        logic                LoadStore;
        logic                ALUSrc;
        logic                RegWrite;
        logic [3:0]          ALUControl;
        logic                BMS;
        logic                illegal;
    } dec_op_t;

    localparam int OP_W = $bits(dec_op_t);

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_lane.sv
// ============================================================================
// Module : decode_lane
// Brief  : Combinational single-instruction decoder, instr+pc -> dec_op_t.
//          Optional illegal-encoding flag: DECODE_ILLEGAL_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_lane
    import decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [31:0]    instr,
    input  logic [PC_W-1:0] pc,
    output dec_op_t        op
);

    logic [6:0] w_opcode;
    logic [2:0] w_func3;
    dec_op_t    w_dec;

    assign w_opcode = instr[6:0];
    assign w_func3  = instr[14:12];

    always_comb begin
        w_dec    = '0;
        w_dec.pc = PC_W_MAX'(pc);
        case (w_opcode)
            OPC_R: begin
                w_dec.opcode     = w_opcode;
                w_dec.rd         = instr[11:7];
                w_dec.rs1        = instr[19:15];
                w_dec.rs2        = instr[24:20];
                w_dec.func3      = w_func3;
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUControl = (w_func3 == 3'b000) ? ALU_ADD : ALU_XOR;
            end
            OPC_I: begin
                w_dec.opcode   = w_opcode;
                w_dec.rd       = instr[11:7];
                w_dec.rs1      = instr[19:15];
                w_dec.func3    = w_func3;
                w_dec.ALUSrc   = 1'b1;
                w_dec.RegWrite = 1'b1;
                case (w_func3)
                    3'b000: begin
                        w_dec.ALUControl = ALU_ADD;
                        w_dec.imm        = sext12(instr[31:20]);
                    end
                    3'b110: begin
                        w_dec.ALUControl = ALU_OR;
                        w_dec.imm        = sext12(instr[31:20]);
                    end
                    3'b101: begin
                        w_dec.ALUControl = ALU_SRA;
                        w_dec.imm        = {27'd0, instr[24:20]};
                    end
                    default: w_dec.ALUControl = ALU_NOP;
                endcase
            end
            OPC_LOAD: begin
                w_dec.opcode     = w_opcode;
                w_dec.rd         = instr[11:7];
                w_dec.rs1        = instr[19:15];
                w_dec.func3      = w_func3;
                w_dec.imm        = sext12(instr[31:20]);
                w_dec.LoadStore  = 1'b1;
                w_dec.ALUSrc     = 1'b1;
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUControl = ALU_ADD;
                w_dec.BMS        = (w_func3 == 3'b000);
            end
            OPC_STORE: begin
                w_dec.opcode     = w_opcode;
                w_dec.rs1        = instr[19:15];
                w_dec.rs2        = instr[24:20];
                w_dec.func3      = w_func3;
                w_dec.imm        = sext12({instr[31:25], instr[11:7]});
                w_dec.LoadStore  = 1'b1;
                w_dec.ALUSrc     = 1'b1;
                w_dec.ALUControl = ALU_ADD;
                w_dec.BMS        = (w_func3 == 3'b000);
            end
            OPC_LUI: begin
                w_dec.opcode     = w_opcode;
                w_dec.rd         = instr[11:7];
                w_dec.imm        = {instr[31:12], 12'b0};
                w_dec.ALUSrc     = 1'b1;
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUControl = ALU_PASS;
            end
            default: w_dec.ALUControl = ALU_NOP;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic w_illegal;

    always_comb begin
        case (w_opcode)
            OPC_R:     w_illegal = !(w_func3 == 3'b000 || w_func3 == 3'b100);
            OPC_I:     w_illegal = !(w_func3 == 3'b000 || w_func3 == 3'b110 ||
                                     w_func3 == 3'b101);
            OPC_LOAD,
            OPC_STORE: w_illegal = !(w_func3 == 3'b000 || w_func3 == 3'b010);
            OPC_LUI:   w_illegal = 1'b0;
            default:   w_illegal = 1'b1;
        endcase
    end

    // Flagged entries keep only the PC so the trap handler can locate them.
    always_comb begin
        op = w_dec;
        if (w_illegal) begin
            op         = '0;
            op.pc      = w_dec.pc;
            op.illegal = 1'b1;
        end
    end
`else
    assign op = w_dec;
`endif

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// Module : decode_queue
// Brief  : WIDTH-lane decode stage feeding a DEPTH-entry in-order output queue.
//          Optional illegal-encoding flag: DECODE_ILLEGAL_TRAP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_queue
    import decode_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in_valid,
    input  logic [32*WIDTH-1:0]          in_instr,
    input  logic [PC_W*WIDTH-1:0]        in_pc,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_valid,
    output logic [OP_W*WIDTH-1:0]        out_op,
    input  logic [$clog2(WIDTH+1)-1:0]   out_accept,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    dec_op_t          w_lane_op [WIDTH];
    dec_op_t          r_mem     [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_n_in;
    logic [CNT_W-1:0] w_n_avail;
    logic [CNT_W-1:0] w_n_out;
    logic             w_ready;
    logic             w_run;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            decode_lane #(
                .PC_W (PC_W)
            ) u_lane (
                .instr (in_instr[32*i +: 32]),
                .pc    (in_pc[PC_W*i +: PC_W]),
                .op    (w_lane_op[i])
            );
        end
    endgenerate

    // Readiness depends on occupancy alone so it never waits on out_accept.
    assign w_ready = (r_count <= CNT_W'(DEPTH - WIDTH));

    always_comb begin
        w_n_in = '0;
        w_run  = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            w_run = w_run & in_valid[k];
            if (w_run) w_n_in = w_n_in + CNT_W'(1);
        end
        if (!w_ready) w_n_in = '0;
    end

    assign w_n_avail = (r_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : r_count;
    assign w_n_out   = (CNT_W'(out_accept) > w_n_avail) ? w_n_avail : CNT_W'(out_accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (CNT_W'(k) < w_n_in) r_mem[r_tail + PTR_W'(k)] <= w_lane_op[k];
            end
            r_tail  <= r_tail + PTR_W'(w_n_in);
            r_head  <= r_head + PTR_W'(w_n_out);
            r_count <= r_count + w_n_in - w_n_out;
        end
    end

    generate
        for (i = 0; i < WIDTH; i++) begin : g_out
            assign out_valid[i]          = (r_count > CNT_W'(i));
            assign out_op[OP_W*i +: OP_W] = r_mem[r_head + PTR_W'(i)];
        end
    endgenerate

    assign in_ready = w_ready;
    assign count    = r_count;

endmodule

`default_nettype wire
